// File: rtl/fb_pkg.sv
// ============================================================================
// Module      : fb_pkg
// Description : Shared types and constants for the frame-buffer port B path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fb_pkg;

  localparam int FB_ADDR_W     = 19;
  // Cycles from request acceptance to read data at the requester.
  localparam int FB_RD_LATENCY = 2;

  typedef enum logic {
    OWN_DISP   = 1'b0,
    OWN_WRITER = 1'b1
  } fb_owner_e;

  typedef struct packed {
    logic      valid;
    fb_owner_e owner;
  } fb_rd_tag_t;

endpackage

`default_nettype wire

// File: rtl/fb_rd_tag_pipe.sv
// ============================================================================
// Module      : fb_rd_tag_pipe
// Description : Read-return tag shift register, depth equal to memory latency.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fb_rd_tag_pipe
  import fb_pkg::*;
#(
  parameter int DEPTH = FB_RD_LATENCY
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       flush,
  input  fb_rd_tag_t tag_in,
  output fb_rd_tag_t tag_out
);

  fb_rd_tag_t [DEPTH-1:0] r_stage;

  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_stage <= '0;
        end else if (flush) begin
          r_stage <= '0;
        end else begin
          r_stage[0] <= tag_in;
        end
      end
    end else begin : g_shift
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_stage <= '0;
        end else if (flush) begin
          r_stage <= '0;
        end else begin
          r_stage <= {r_stage[DEPTH-2:0], tag_in};
        end
      end
    end
  endgenerate

  assign tag_out = r_stage[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/fb_port_arbiter.sv
// ============================================================================
// Module      : fb_port_arbiter
// Description : Two-requester arbiter for memory port B, display has priority
//               with a starvation guard for the pixel writer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fb_port_arbiter
  import fb_pkg::*;
#(
  parameter int ADDR_W   = FB_ADDR_W,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              d_valid,
  output logic              d_ready,
  input  logic [ADDR_W-1:0] d_addr,
  output logic              d_rvalid,
  output logic [7:0]        d_rdata,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic              w_write,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [7:0]        w_wdata,
  output logic              w_rvalid,
  output logic [7:0]        w_rdata,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_chipselect,
  output logic              m_write,
  output logic [7:0]        m_writedata,
  output logic              m_clken,
  input  logic [7:0]        m_readdata
);

  localparam logic [7:0] c_max_wait = 8'(MAX_WAIT);
  localparam logic [7:0] c_cnt_sat  = 8'hFF;

  logic [7:0]        r_wait_cnt;
  logic              r_cs;
  logic              r_wr;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_wdata;

  logic       w_starve;
  logic       w_disp_acc;
  logic       w_wr_acc;
  fb_rd_tag_t w_tag_in;
  fb_rd_tag_t w_tag_out;

  // Starve only matters while the writer is actually asking.
  assign w_starve   = (r_wait_cnt >= c_max_wait);
  assign d_ready    = d_valid && !(w_starve && w_valid);
  assign w_ready    = w_valid && (w_starve || !d_valid);
  assign w_disp_acc = d_valid && d_ready;
  assign w_wr_acc   = w_valid && w_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wait_cnt <= '0;
    end else if (!w_valid || w_wr_acc) begin
      r_wait_cnt <= '0;
    end else if (r_wait_cnt != c_cnt_sat) begin
      r_wait_cnt <= r_wait_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cs    <= 1'b0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_cs <= w_disp_acc || w_wr_acc;
      r_wr <= w_wr_acc && w_write;
      if (w_disp_acc) begin
        r_addr <= d_addr;
      end else if (w_wr_acc) begin
        r_addr <= w_addr;
      end
      if (w_wr_acc && w_write) begin
        r_wdata <= w_wdata;
      end
    end
  end

  always_comb begin
    w_tag_in       = '0;
    w_tag_in.valid = w_disp_acc || (w_wr_acc && !w_write);
    w_tag_in.owner = w_wr_acc ? OWN_WRITER : OWN_DISP;
  end

  fb_rd_tag_pipe #(
    .DEPTH (FB_RD_LATENCY)
  ) u_rd_tag_pipe (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (1'b0),
    .tag_in  (w_tag_in),
    .tag_out (w_tag_out)
  );

  assign m_address    = r_addr;
  assign m_chipselect = r_cs;
  assign m_write      = r_wr;
  assign m_writedata  = r_wdata;
  assign m_clken      = 1'b1;

  assign d_rvalid = w_tag_out.valid && (w_tag_out.owner == OWN_DISP);
  assign w_rvalid = w_tag_out.valid && (w_tag_out.owner == OWN_WRITER);
  assign d_rdata  = m_readdata;
  assign w_rdata  = m_readdata;

endmodule

`default_nettype wire

// File: tb/tb_fb_port_arbiter.sv
// ============================================================================
// Module      : tb_fb_port_arbiter
// Description : Directed self-checking bench with read-return scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fb_port_arbiter;

  localparam int AW = 19;
  localparam int MW = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          d_valid, d_ready, d_rvalid;
  logic [AW-1:0] d_addr;
  logic [7:0]    d_rdata;
  logic          w_valid, w_ready, w_write, w_rvalid;
  logic [AW-1:0] w_addr;
  logic [7:0]    w_wdata, w_rdata;
  logic [AW-1:0] m_address;
  logic          m_chipselect, m_write, m_clken;
  logic [7:0]    m_writedata, m_readdata;

  fb_port_arbiter #(.ADDR_W(AW), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset_n(reset_n),
    .d_valid(d_valid), .d_ready(d_ready), .d_addr(d_addr),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .w_valid(w_valid), .w_ready(w_ready), .w_write(w_write), .w_addr(w_addr),
    .w_wdata(w_wdata), .w_rvalid(w_rvalid), .w_rdata(w_rdata),
    .m_address(m_address), .m_chipselect(m_chipselect), .m_write(m_write),
    .m_writedata(m_writedata), .m_clken(m_clken), .m_readdata(m_readdata)
  );

  always #5 clk = ~clk;

  // Port B memory: address registered on the command cycle, data next cycle.
  logic [7:0] mem [0:1023];
  logic       mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'(i);
      mem_init <= 1'b1;
    end else if (m_chipselect && m_clken) begin
      if (m_write) mem[m_address[9:0]] <= m_writedata;
      m_readdata <= mem[m_address[9:0]];
    end
  end

  typedef struct {
    logic       owner;
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t          sb[$];
  logic [7:0]    shadow [0:1023];
  int            total = 0;
  int            bad   = 0;
  int            cyc   = 0;
  int            cnt   = 0;
  logic          exp_cs, exp_wr;
  logic [AW-1:0] exp_addr;
  logic [7:0]    exp_wd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    exp_cs   = 1'b0;
    exp_wr   = 1'b0;
    exp_addr = '0;
    exp_wd   = '0;
    cnt      = 0;
  endtask

  // Inputs are set just after posedge; everything is sampled at negedge.
  task automatic tick();
    exp_t e;
    logic starve, exp_dr, exp_wrr;
    @(negedge clk);
    starve  = (cnt >= MW);
    exp_dr  = d_valid && !(starve && w_valid);
    exp_wrr = w_valid && (starve || !d_valid);
    chk("d_ready", 32'(d_ready), 32'(exp_dr));
    chk("w_ready", 32'(w_ready), 32'(exp_wrr));
    chk("m_clken", 32'(m_clken), 32'd1);
    chk("m_chipselect", 32'(m_chipselect), 32'(exp_cs));
    chk("m_write", 32'(m_write), 32'(exp_wr));
    chk("m_address", 32'(m_address), 32'(exp_addr));
    if (exp_wr) chk("m_writedata", 32'(m_writedata), 32'(exp_wd));

    if (d_rvalid || w_rvalid) begin
      chk("rvalid_both", 32'(d_rvalid && w_rvalid), 32'd0);
      if (sb.size() == 0) begin
        chk("rvalid_unexpected", 32'({d_rvalid, w_rvalid}), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("ret_owner", 32'(w_rvalid), 32'(e.owner));
        chk("ret_cycle", 32'(cyc), 32'(e.due));
        chk("ret_data", 32'(w_rvalid ? w_rdata : d_rdata), 32'(e.data));
      end
    end else if (sb.size() != 0 && sb[0].due <= cyc) begin
      chk("ret_missing", 32'(d_rvalid || w_rvalid), 32'd1);
      e = sb.pop_front();
    end

    if (exp_dr) begin
      e.owner = 1'b0;
      e.data  = shadow[d_addr[9:0]];
      e.due   = cyc + 2;
      sb.push_back(e);
      exp_cs   = 1'b1;
      exp_wr   = 1'b0;
      exp_addr = d_addr;
    end else if (exp_wrr) begin
      exp_cs   = 1'b1;
      exp_wr   = w_write;
      exp_addr = w_addr;
      if (w_write) begin
        shadow[w_addr[9:0]] = w_wdata;
        exp_wd = w_wdata;
      end else begin
        e.owner = 1'b1;
        e.data  = shadow[w_addr[9:0]];
        e.due   = cyc + 2;
        sb.push_back(e);
      end
    end else begin
      exp_cs = 1'b0;
      exp_wr = 1'b0;
    end
    if (w_valid && !exp_wrr) cnt = (cnt < 255) ? cnt + 1 : 255;
    else                     cnt = 0;

    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive_idle();
    d_valid = 1'b0; d_addr = '0;
    w_valid = 1'b0; w_write = 1'b0; w_addr = '0; w_wdata = '0;
  endtask

  initial begin
    int wk;
    for (int i = 0; i < 1024; i++) shadow[i] = 8'(i);
    reset_n = 1'b0;
    drive_idle();
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    chk("rst_d_ready", 32'(d_ready), 32'd0);
    chk("rst_w_ready", 32'(w_ready), 32'd0);
    chk("rst_m_chipselect", 32'(m_chipselect), 32'd0);
    chk("rst_m_write", 32'(m_write), 32'd0);
    chk("rst_m_address", 32'(m_address), 32'd0);
    chk("rst_m_writedata", 32'(m_writedata), 32'd0);
    chk("rst_m_clken", 32'(m_clken), 32'd1);
    chk("rst_d_rvalid", 32'(d_rvalid), 32'd0);
    chk("rst_w_rvalid", 32'(w_rvalid), 32'd0);
    reset_n = 1'b1;

    // Idle after reset.
    repeat (10) tick();

    // Display streaming reads 0..15.
    for (int i = 0; i < 16; i++) begin
      d_valid = 1'b1;
      d_addr  = AW'(i);
      tick();
    end
    drive_idle();
    repeat (3) tick();

    // Writer write then read-back of the same byte.
    w_valid = 1'b1; w_write = 1'b1; w_addr = AW'(32'h100); w_wdata = 8'hA5;
    tick();
    w_write = 1'b0;
    tick();
    drive_idle();
    repeat (3) tick();

    // Display saturating the port: writer gets every 9th slot.
    wk = 0;
    for (int k = 0; k < 27; k++) begin
      d_valid = 1'b1; d_addr = AW'(32'h40 + k);
      w_valid = 1'b1; w_write = 1'b0; w_addr = AW'(32'h200 + wk);
      #1;
      chk("starve_slot_w", 32'(w_ready), 32'((k % 9) == 8));
      chk("starve_slot_d", 32'(d_ready), 32'((k % 9) != 8));
      tick();
      if ((k % 9) == 8) wk++;
    end
    drive_idle();
    repeat (3) tick();

    // Alternating single requesters.
    for (int k = 0; k < 8; k++) begin
      drive_idle();
      if ((k % 2) == 0) begin
        d_valid = 1'b1; d_addr = AW'(32'h80 + k);
      end else begin
        w_valid = 1'b1; w_addr = AW'(32'h300 + k);
      end
      tick();
    end
    drive_idle();
    repeat (3) tick();

    // Reset with two display reads in flight.
    d_valid = 1'b1; d_addr = AW'(5);
    tick();
    d_addr = AW'(6);
    tick();
    drive_idle();
    chk("inflight_d_rvalid", 32'(d_rvalid), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("midrst_d_rvalid", 32'(d_rvalid), 32'd0);
    chk("midrst_w_rvalid", 32'(w_rvalid), 32'd0);
    chk("midrst_m_chipselect", 32'(m_chipselect), 32'd0);
    chk("midrst_m_address", 32'(m_address), 32'd0);
    chk("midrst_m_write", 32'(m_write), 32'd0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (5) tick();

    // Final idle stretch.
    repeat (10) tick();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fb_port_arbiter.md
# fb_port_arbiter

Shares the 8-bit byte port (port B) of the on-chip system memory between two requesters: the display scanout reader (read-only, latency-critical) and the pixel writer (read/write, used by game drawing). Fixed priority to the scanout reader with a starvation guard for the writer. Registers the memory command and routes each read return to the requester that issued it. Sits between the two requesters and the memory's `address2/chipselect2/write2/writedata2/clken2/readdata2` pins.

## Interface
- `ADDR_W`, 19, byte address width of port B
- `MAX_WAIT`, 8, cycles a writer request may stay blocked before it is forced through; legal range 1..255
- `clk`  in  1  system clock
- `reset_n`  in  1  asynchronous, active-low reset
- `d_valid`  in  1  display read request
- `d_ready`  out  1  display request accepted this cycle
- `d_addr`  in  ADDR_W  display byte address
- `d_rvalid`  out  1  display read data valid
- `d_rdata`  out  8  display read data
- `w_valid`  in  1  writer request
- `w_ready`  out  1  writer request accepted this cycle
- `w_write`  in  1  1 = write, 0 = read
- `w_addr`  in  ADDR_W  writer byte address
- `w_wdata`  in  8  writer write data
- `w_rvalid`  out  1  writer read data valid
- `w_rdata`  out  8  writer read data
- `m_address`  out  ADDR_W  to memory `address2`
- `m_chipselect`  out  1  to `chipselect2`
- `m_write`  out  1  to `write2`
- `m_writedata`  out  8  to `writedata2`
- `m_clken`  out  1  to `clken2`, constant 1
- `m_readdata`  in  8  from `readdata2`

## Operation
- One request accepted per cycle at most. Handshake: transfer when `x_valid && x_ready`. `x_ready` is combinational from valids and the starvation state, never gated by its own `x_valid` path to itself (no loop).
- Arbitration: writer wins if `starve` is set; otherwise display wins if `d_valid`; otherwise writer wins if `w_valid`.
- Starvation counter `wait_cnt` (8 bit): increments each cycle `w_valid && !w_ready`; clears on writer acceptance or `!w_valid`. `starve` = `wait_cnt >= MAX_WAIT`. Saturates at 255.
- Accepted request is registered onto `m_*` next cycle; `m_chipselect` = 1 for exactly that cycle, 0 when idle. `m_write` = 1 only for writer writes. Idle cycles hold previous `m_address`.
- Read-return tag: 2-stage shift register of {valid, owner}. Stage 0 loads on any accepted read; stage 1 qualifies `m_readdata`. `d_rvalid`/`w_rvalid` pulse one cycle from stage 1; both rdata outputs drive `m_readdata` directly (qualified by rvalid).
- Writes produce no return. Returns are in order; no reordering.
- Reset mid-operation: all in-flight tags are dropped, no rvalid after reset asserts.

## Timing
- Reset values: `d_ready`=`w_ready` combinational (0 at reset with no valids), `m_chipselect`=0, `m_write`=0, `m_address`=0, `m_writedata`=0, `m_clken`=1, `d_rvalid`=`w_rvalid`=0, `wait_cnt`=0, tags cleared.
- Accept in cycle N -> `m_*` command in N+1 -> memory registers address at end of N+1 -> `x_rvalid` with data in N+2. Read latency 2 cycles, fully pipelined, throughput 1/cycle.
- Simultaneous `d_valid` and `w_valid` with `starve`=0: display accepted, `wait_cnt` increments.
- Writer read-after-write to same address issued back-to-back returns the new data (memory same-port behaviour).
- Constant `d_valid`: writer gets exactly one slot every `MAX_WAIT+1` cycles.

## Structure
- Shared package `fb_pkg`: `FB_ADDR_W`=19, owner enum `{OWN_DISP, OWN_WRITER}`, tag struct {valid, owner}.
- One sub-module natural: `fb_rd_tag_pipe` (parameterised-depth tag shift register with synchronous flush), reused if memory latency changes.

## Test plan
- Display-only reads addrs 0..15 every cycle, memory preloaded with byte = addr -> `d_rvalid` continuous from cycle 2, `d_rdata` 0..15 in order, `w_rvalid` never.
- Writer write 0xA5 to 0x00100 then read 0x00100 next cycle -> `m_write` pulse one cycle, `w_rvalid` 2 cycles after read acceptance with 0xA5.
- `d_valid` held high, `w_valid` high, MAX_WAIT=8 -> writer accepted on 9th cycle, then again every 9 cycles; display never loses more than 1 consecutive slot.
- Alternating display/writer reads, both valid, `starve` forced -> returns routed to correct owner, no swapped data.
- Assert `reset_n` low with two reads in flight -> all outputs at reset values immediately, no rvalid after release.
- Idle 10 cycles -> `m_chipselect` stays 0, `m_clken` stays 1, `wait_cnt` stays 0.
